lcd_frame_streamer: RTL and testbench

- Display-side consumer of the pixel RAM interface.
- Sweeps ram_addr_x/ram_addr_y in raster order across the 128x160 panel and captures the registered 16-bit RGB565 ram_data returned by the grid renderer.
- Serializes a window-setup command header plus every pixel over a 4-wire SPI link (SCK/MOSI/DC/CS) to the ST7735-class LCD.
- One frame per start request.

---
 rtl/lcd_frame_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_frame_streamer.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_streamer.sv
// Raster-scans the pixel RAM and streams a window header plus RGB565 pixels to an
// ST7735-class panel over SPI mode 0. Optional macro: LCD_STREAM_CONTINUOUS_EN.
module lcd_frame_streamer #(
    parameter int H_RES   = 128,
    parameter int V_RES   = 160,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ram_data,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    output logic        lcd_sck,
    output logic        lcd_mosi,
    output logic        lcd_dc,
    output logic        lcd_cs,
    output logic        busy,
    output logic        frame_done
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] PIX  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef LCD_STREAM_CONTINUOUS_EN
    localparam logic [2:0] GAP     = 3'd4;
    // DONE plus 15 GAP clks gives 16 clks of cs high between frames
    localparam logic [3:0] GAP_END = 4'd14;
`endif

    localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]         X_LAST   = 8'(H_RES - 1);
    localparam logic [7:0]         Y_LAST   = 8'(V_RES - 1);
    localparam logic [3:0]         HDR_LAST = 4'd10;

    // Header table entries are {dc, byte}; entries past index 10 are never sent.
    function automatic logic [8:0] hdr_entry(input int idx);
        case (idx)
            0:       return {1'b0, 8'h2A};
            4:       return {1'b1, X_LAST};
            5:       return {1'b0, 8'h2B};
            9:       return {1'b1, Y_LAST};
            10:      return {1'b0, 8'h2C};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    logic [8:0] hdr_rom [16];
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hdr
            assign hdr_rom[gi] = hdr_entry(gi);
        end
    endgenerate

    logic [2:0]       state_reg;
    logic [DIV_W-1:0] div_reg;
    logic             sck_reg;
    logic             cs_reg;
    logic             dc_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             last_pix_reg;
    logic [15:0]      shift_reg;
    logic [3:0]       bit_cnt_reg;
    logic [3:0]       byte_idx_reg;
    logic [7:0]       addr_x_reg;
    logic [7:0]       addr_y_reg;
`ifdef LCD_STREAM_CONTINUOUS_EN
    logic [3:0]       gap_cnt_reg;
`endif

    logic [7:0] addr_x_next;
    logic [7:0] addr_y_next;
    logic [3:0] byte_idx_inc;
    logic [3:0] last_bit;
    logic       phase_end;
    logic       launch;

    assign byte_idx_inc = byte_idx_reg + 4'd1;
    assign last_bit     = (state_reg == HDR) ? 4'd7 : 4'd15;
    assign phase_end    = (div_reg == DIV_LAST);

    always_comb begin
        addr_x_next = addr_x_reg + 8'd1;
        addr_y_next = addr_y_reg;
        if (addr_x_reg == X_LAST) begin
            addr_x_next = 8'd0;
            addr_y_next = (addr_y_reg == Y_LAST) ? 8'd0 : addr_y_reg + 8'd1;
        end
    end

    always_comb begin
        launch = (state_reg == IDLE) && start;
`ifdef LCD_STREAM_CONTINUOUS_EN
        if (state_reg == GAP && gap_cnt_reg == GAP_END) begin
            launch = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            div_reg        <= '0;
            sck_reg        <= 1'b0;
            cs_reg         <= 1'b1;
            dc_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            last_pix_reg   <= 1'b0;
            shift_reg      <= 16'h0000;
            bit_cnt_reg    <= 4'd0;
            byte_idx_reg   <= 4'd0;
            addr_x_reg     <= 8'd0;
            addr_y_reg     <= 8'd0;
`ifdef LCD_STREAM_CONTINUOUS_EN
            gap_cnt_reg    <= 4'd0;
`endif
        end else if (launch) begin
            // First low phase starts in the same clk that cs falls
            state_reg      <= HDR;
            busy_reg       <= 1'b1;
            cs_reg         <= 1'b0;
            sck_reg        <= 1'b0;
            div_reg        <= '0;
            bit_cnt_reg    <= 4'd0;
            byte_idx_reg   <= 4'd0;
            last_pix_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            shift_reg      <= {hdr_rom[0][7:0], 8'h00};
            dc_reg         <= hdr_rom[0][8];
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                HDR, PIX: begin
                    if (!phase_end) begin
                        div_reg <= div_reg + DIV_W'(1);
                    end else begin
                        div_reg <= '0;
                        sck_reg <= ~sck_reg;
                        if (sck_reg) begin
                            if (bit_cnt_reg != last_bit) begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                                shift_reg   <= {shift_reg[14:0], 1'b0};
                            end else begin
                                bit_cnt_reg <= 4'd0;
                                if (state_reg == HDR && byte_idx_reg != HDR_LAST) begin
                                    byte_idx_reg <= byte_idx_inc;
                                    shift_reg    <= {hdr_rom[byte_idx_inc][7:0], 8'h00};
                                    dc_reg       <= hdr_rom[byte_idx_inc][8];
                                end else if (state_reg == PIX && last_pix_reg) begin
                                    state_reg      <= DONE;
                                    cs_reg         <= 1'b1;
                                    busy_reg       <= 1'b0;
                                    frame_done_reg <= 1'b1;
                                    dc_reg         <= 1'b0;
                                    shift_reg      <= 16'h0000;
                                end else begin
                                    // Capture the pixel, then move the address on so the RAM
                                    // has the whole next pixel time to settle
                                    state_reg    <= PIX;
                                    shift_reg    <= ram_data;
                                    dc_reg       <= 1'b1;
                                    last_pix_reg <= (addr_x_reg == X_LAST) && (addr_y_reg == Y_LAST);
                                    addr_x_reg   <= addr_x_next;
                                    addr_y_reg   <= addr_y_next;
                                end
                            end
                        end
                    end
                end
                DONE: begin
`ifdef LCD_STREAM_CONTINUOUS_EN
                    state_reg   <= GAP;
                    gap_cnt_reg <= 4'd0;
`else
                    state_reg   <= IDLE;
`endif
                end
`ifdef LCD_STREAM_CONTINUOUS_EN
                GAP: begin
                    gap_cnt_reg <= gap_cnt_reg + 4'd1;
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ram_addr_x = addr_x_reg;
    assign ram_addr_y = addr_y_reg;
    assign lcd_sck    = sck_reg;
    assign lcd_mosi   = shift_reg[15];
    assign lcd_dc     = dc_reg;
    assign lcd_cs     = cs_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Bench for lcd_frame_streamer: two 4x2 instances (CLK_DIV 1 and 3) driven by a RAM model,
// an SPI slave decoder and a frame-level reference of the expected byte stream.
module tb_lcd_frame_streamer;
    localparam int H        = 4;
    localparam int V        = 2;
    localparam int NPIX     = H * V;
    localparam int DIV0     = 1;
    localparam int DIV1     = 3;
    localparam int HDR_BITS = 88;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [15:0] ram_data [2];
    logic [1:0]  sck, mosi, dc, cs, busy, fd;
    logic [7:0]  ax [2];
    logic [7:0]  ay [2];
    logic [15:0] mem [2][NPIX];

    int errors = 0;
    int checks = 0;
    bit abort_ok = 1'b0;

    logic p_sck  [2] = '{1'b0, 1'b0};
    logic p_cs   [2] = '{1'b1, 1'b1};
    logic p_mosi [2] = '{1'b0, 1'b0};
    logic p_dc   [2] = '{1'b0, 1'b0};
    logic p_fd   [2] = '{1'b0, 1'b0};
    logic bdc    [2] = '{1'b0, 1'b0};
    logic [7:0] shv [2] = '{8'h00, 8'h00};
    int run_len [2] = '{0, 0};
    int nbits   [2] = '{0, 0};
    int cs_low  [2] = '{0, 0};
    int fd_cnt  [2] = '{0, 0};

    logic [8:0] rx0[$], rx1[$], got_q[$], exp_q[$];
    int csq0[$], csq1[$], csg[$];

    lcd_frame_streamer #(.H_RES(H), .V_RES(V), .CLK_DIV(DIV0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .ram_data(ram_data[0]),
        .ram_addr_x(ax[0]), .ram_addr_y(ay[0]), .lcd_sck(sck[0]), .lcd_mosi(mosi[0]),
        .lcd_dc(dc[0]), .lcd_cs(cs[0]), .busy(busy[0]), .frame_done(fd[0])
    );

    lcd_frame_streamer #(.H_RES(H), .V_RES(V), .CLK_DIV(DIV1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .ram_data(ram_data[1]),
        .ram_addr_x(ax[1]), .ram_addr_y(ay[1]), .lcd_sck(sck[1]), .lcd_mosi(mosi[1]),
        .lcd_dc(dc[1]), .lcd_cs(cs[1]), .busy(busy[1]), .frame_done(fd[1])
    );

    // Registered-read pixel RAM, one per instance
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ax[i] < 8'(H) && ay[i] < 8'(V))
                ram_data[i] <= mem[i][int'(ay[i]) * H + int'(ax[i])];
            else
                ram_data[i] <= 16'hDEAD;
        end
    end

    // SPI slave and link-timing monitor, sampled on the falling clk edge
    task automatic mon(input int i);
        logic c_sck, c_cs, c_mosi, c_dc, c_fd, c_busy;
        logic [7:0] nb;
        int exp_div;
        c_sck  = sck[i];
        c_cs   = cs[i];
        c_mosi = mosi[i];
        c_dc   = dc[i];
        c_fd   = fd[i];
        c_busy = busy[i];
        exp_div = (i == 0) ? DIV0 : DIV1;
        checks++;
        if (c_busy !== ~c_cs) begin
            errors++;
            $display("FAIL busy_vs_cs inst=%0d busy=%b cs=%b (busy must be ~cs) t=%0t", i, c_busy, c_cs, $time);
        end
        if (c_cs === 1'b1) begin
            checks++;
            if (c_sck !== 1'b0) begin
                errors++;
                $display("FAIL sck_idle inst=%0d sck=%b expected 0 t=%0t", i, c_sck, $time);
            end
        end
        if (c_fd === 1'b1) begin
            fd_cnt[i]++;
            checks++;
            if (c_cs !== 1'b1 || c_busy !== 1'b0 || p_fd[i] === 1'b1) begin
                errors++;
                $display("FAIL frame_done_pulse inst=%0d cs=%b busy=%b prev_fd=%b expected 1/0/0 t=%0t",
                         i, c_cs, c_busy, p_fd[i], $time);
            end
        end
        if (p_cs[i] === 1'b0) begin
            if (c_cs === 1'b1 || c_sck !== p_sck[i]) begin
                if (!abort_ok) begin
                    checks++;
                    if (run_len[i] != exp_div) begin
                        errors++;
                        $display("FAIL half_period inst=%0d got=%0d expected=%0d t=%0t", i, run_len[i], exp_div, $time);
                    end
                end
                run_len[i] = 1;
            end else begin
                run_len[i]++;
            end
            if (c_cs === 1'b0 && (c_mosi !== p_mosi[i] || c_dc !== p_dc[i])) begin
                checks++;
                if (!(c_sck === 1'b0 && p_sck[i] === 1'b1)) begin
                    errors++;
                    $display("FAIL mosi_dc_change inst=%0d sck=%b prev_sck=%b expected change only at low-phase start t=%0t",
                             i, c_sck, p_sck[i], $time);
                end
            end
            if (c_cs === 1'b0 && c_sck === 1'b1 && p_sck[i] === 1'b0) begin
                if (nbits[i] == 0) bdc[i] = c_dc;
                nb = {shv[i][6:0], c_mosi};
                shv[i] = nb;
                nbits[i]++;
                if (nbits[i] == 8) begin
                    nbits[i] = 0;
                    if (i == 0) rx0.push_back({bdc[i], nb});
                    else        rx1.push_back({bdc[i], nb});
                end
            end
            if (c_cs === 1'b1) begin
                if (i == 0) csq0.push_back(cs_low[i]);
                else        csq1.push_back(cs_low[i]);
                if (!abort_ok) begin
                    checks++;
                    if (nbits[i] != 0) begin
                        errors++;
                        $display("FAIL partial_byte inst=%0d bits=%0d expected 0 t=%0t", i, nbits[i], $time);
                    end
                end
                nbits[i]  = 0;
                cs_low[i] = 0;
            end else begin
                cs_low[i]++;
            end
        end else if (c_cs === 1'b0) begin
            cs_low[i]  = 1;
            run_len[i] = 1;
            nbits[i]   = 0;
            checks++;
            if (c_sck !== 1'b0) begin
                errors++;
                $display("FAIL first_phase inst=%0d sck=%b expected 0 t=%0t", i, c_sck, $time);
            end
        end
        p_sck[i]  = c_sck;
        p_cs[i]   = c_cs;
        p_mosi[i] = c_mosi;
        p_dc[i]   = c_dc;
        p_fd[i]   = c_fd;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Reference: header with window bounds, then every pixel in raster order, hi byte first
    task automatic build_exp(input int i);
        logic [15:0] p;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h2A});
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(H - 1)});
        exp_q.push_back({1'b0, 8'h2B});
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'(V - 1)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p = mem[i][y * H + x];
                exp_q.push_back({1'b1, p[15:8]});
                exp_q.push_back({1'b1, p[7:0]});
            end
        end
    endtask

    task automatic fill_random(input int i);
        for (int k = 0; k < NPIX; k++) mem[i][k] = 16'($urandom);
    endtask

    task automatic clear_rx(input int i);
        if (i == 0) begin rx0.delete(); csq0.delete(); end
        else        begin rx1.delete(); csq1.delete(); end
    endtask

    task automatic grab(input int i);
        if (i == 0) begin got_q = rx0; csg = csq0; end
        else        begin got_q = rx1; csg = csq1; end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget, output bit timeout);
        timeout = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (fd[i] === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    function automatic int cs_low_exp(input int div);
        return (HDR_BITS + 16 * NPIX) * 2 * div;
    endfunction

    task automatic test_reset_idle();
        logic [19:0] idle_exp;
        idle_exp = {1'b1, 19'd0};
        rst = 1'b1;
        start = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({cs[i], sck[i], busy[i], fd[i], ax[i], ay[i]} !== idle_exp) begin
                    errors++;
                    $display("FAIL reset_idle inst=%0d cyc=%0d {cs,sck,busy,fd,x,y}=%h expected %h",
                             i, n, {cs[i], sck[i], busy[i], fd[i], ax[i], ay[i]}, idle_exp);
                end
            end
        end
        $display("reset/idle: 100 clks observed on both instances");
    endtask

    task automatic test_frame_pattern();
        bit to;
        int base;
        for (int k = 0; k < NPIX; k++) mem[0][k] = {8'(k % H), 8'(k / H)};
        clear_rx(0);
        base = fd_cnt[0];
        pulse_start(0);
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL pattern_timeout inst=0 frame_done not seen within 2000 clks"); end
        repeat (3) @(negedge clk);
        build_exp(0);
        grab(0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pattern_len got=%0d expected=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL pattern_byte idx=%0d got {dc,byte}=%h expected %h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (csg.size() != 1 || csg[0] != cs_low_exp(DIV0)) begin
            errors++;
            $display("FAIL pattern_cs_low frames=%0d got=%0d expected=%0d", csg.size(), csg[0], cs_low_exp(DIV0));
        end
        checks++;
        if (fd_cnt[0] - base != 1) begin
            errors++;
            $display("FAIL pattern_done_count got=%0d expected=1", fd_cnt[0] - base);
        end
        checks++;
        if (ax[0] !== 8'd0 || ay[0] !== 8'd0) begin
            errors++;
            $display("FAIL pattern_addr_return got=(%0d,%0d) expected=(0,0)", ax[0], ay[0]);
        end
        $display("frame pattern inst=0 bytes=%0d cs_low=%0d", got_q.size(), csg[0]);
    endtask

    task automatic test_frame_random();
        bit to;
        int base, i, div;
        for (int rep = 0; rep < 4; rep++) begin
            i   = rep % 2;
            div = (i == 0) ? DIV0 : DIV1;
            fill_random(i);
            clear_rx(i);
            base = fd_cnt[i];
            repeat ($urandom_range(0, 7)) @(negedge clk);
            pulse_start(i);
            wait_done(i, 6000, to);
            checks++;
            if (to) begin errors++; $display("FAIL random_timeout inst=%0d rep=%0d", i, rep); end
            repeat (3) @(negedge clk);
            build_exp(i);
            grab(i);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random_len inst=%0d got=%0d expected=%0d", i, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL random_byte inst=%0d idx=%0d got=%h expected=%h", i, k, got_q[k], exp_q[k]);
                end
            end
            checks++;
            if (csg.size() != 1 || csg[0] != cs_low_exp(div)) begin
                errors++;
                $display("FAIL random_cs_low inst=%0d frames=%0d got=%0d expected=%0d", i, csg.size(), csg[0], cs_low_exp(div));
            end
            checks++;
            if (fd_cnt[i] - base != 1) begin
                errors++;
                $display("FAIL random_done_count inst=%0d got=%0d expected=1", i, fd_cnt[i] - base);
            end
            $display("frame random inst=%0d div=%0d bytes=%0d cs_low=%0d", i, div, got_q.size(), csg[0]);
        end
    endtask

    task automatic test_start_held();
        bit to;
        int base, n_single;
        fill_random(0);
        clear_rx(0);
        base = fd_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL held_timeout first frame"); end
        @(negedge clk);
        checks++;
        if (cs[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_clk cs=%b busy=%b expected cs=1 busy=0", cs[0], busy[0]);
        end
        @(negedge clk);
        checks++;
        if (cs[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL held_restart cs=%b busy=%b expected cs=0 busy=1", cs[0], busy[0]);
        end
        start[0] = 1'b0;
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL held_timeout second frame"); end
        repeat (3) @(negedge clk);
        build_exp(0);
        n_single = exp_q.size();
        for (int k = 0; k < n_single; k++) exp_q.push_back(exp_q[k]);
        grab(0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL held_len got=%0d expected=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL held_byte idx=%0d got=%h expected=%h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (csg.size() != 2 || csg[0] != cs_low_exp(DIV0) || csg[1] != cs_low_exp(DIV0)) begin
            errors++;
            $display("FAIL held_cs_low frames=%0d got=%0d,%0d expected 2 x %0d", csg.size(), csg[0], csg[1], cs_low_exp(DIV0));
        end
        checks++;
        if (fd_cnt[0] - base != 2) begin
            errors++;
            $display("FAIL held_done_count got=%0d expected=2", fd_cnt[0] - base);
        end
        $display("frame start-held inst=0 frames=%0d bytes=%0d", csg.size(), got_q.size());
    endtask

    task automatic test_reset_mid();
        bit to;
        int base;
        logic [19:0] idle_exp;
        idle_exp = {1'b1, 19'd0};
        fill_random(0);
        clear_rx(0);
        pulse_start(0);
        to = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (rx0.size() >= 21) begin to = 1'b0; break; end
        end
        checks++;
        if (to) begin errors++; $display("FAIL midreset_timeout got=%0d bytes expected>=21", rx0.size()); end
        repeat ($urandom_range(2, 20)) @(negedge clk);
        abort_ok = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cs[0], sck[0], busy[0], fd[0], ax[0], ay[0]} !== idle_exp) begin
            errors++;
            $display("FAIL midreset_state {cs,sck,busy,fd,x,y}=%h expected %h",
                     {cs[0], sck[0], busy[0], fd[0], ax[0], ay[0]}, idle_exp);
        end
        rst = 1'b0;
        @(negedge clk);
        abort_ok = 1'b0;
        fill_random(0);
        clear_rx(0);
        base = fd_cnt[0];
        pulse_start(0);
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL midreset_timeout frame after reset"); end
        repeat (3) @(negedge clk);
        build_exp(0);
        grab(0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_len got=%0d expected=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL midreset_byte idx=%0d got=%h expected=%h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (csg.size() != 1 || csg[0] != cs_low_exp(DIV0) || fd_cnt[0] - base != 1) begin
            errors++;
            $display("FAIL midreset_frame cs_low=%0d frames=%0d done=%0d expected %0d/1/1",
                     csg[0], csg.size(), fd_cnt[0] - base, cs_low_exp(DIV0));
        end
        $display("frame after mid-frame reset inst=0 bytes=%0d cs_low=%0d", got_q.size(), csg[0]);
    endtask

`ifdef LCD_STREAM_CONTINUOUS_EN
    task automatic test_continuous();
        bit to;
        int base, gap, n_single;
        fill_random(0);
        clear_rx(0);
        base = fd_cnt[0];
        pulse_start(0);
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL cont_timeout first frame"); end
        gap = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cs[0] === 1'b0) break;
            gap++;
        end
        checks++;
        if (gap != 16) begin errors++; $display("FAIL cont_gap got=%0d expected=16", gap); end
        wait_done(0, 2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL cont_timeout second frame"); end
        abort_ok = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        abort_ok = 1'b0;
        build_exp(0);
        n_single = exp_q.size();
        for (int k = 0; k < n_single; k++) exp_q.push_back(exp_q[k]);
        grab(0);
        checks++;
        if (got_q.size() != exp_q.size() || fd_cnt[0] - base != 2) begin
            errors++;
            $display("FAIL cont_frames bytes=%0d done=%0d expected %0d/2", got_q.size(), fd_cnt[0] - base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL cont_byte idx=%0d got=%h expected=%h", k, got_q[k], exp_q[k]);
            end
        end
        $display("continuous inst=0 gap=%0d bytes=%0d", gap, got_q.size());
    endtask
`endif

    initial begin
        test_reset_idle();
`ifdef LCD_STREAM_CONTINUOUS_EN
        test_continuous();
`else
        test_frame_pattern();
        test_frame_random();
        test_start_held();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
